gol_grid_engine: RTL and testbench

//  Parametrised Game-of-Life generation engine. Holds a WIDTH x HEIGHT cell grid
//  and advances it one or more generations on request. Uses a programmable

---
 rtl/gol_pkg.sv | 18 +
 rtl/gol_row_rule.sv | 51 +++++
 rtl/gol_grid_engine.sv | 162 ++++++++++++++++
 tb/tb_gol_grid_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life grid engine.
// Contents: engine FSM state type, neighbour-count width, and the standard
// Conway B3/S23 rule masks for hosts that want the classic rule.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT
  } state_t;

  // Neighbour count spans 0..8, so four bits are enough.
  localparam int NBR_W = 4;

  localparam logic [8:0] RULE_CONWAY_B = 9'h008;
  localparam logic [8:0] RULE_CONWAY_S = 9'h00C;

endpackage

// File: rtl/gol_row_rule.sv
// Combinational next-state for one grid row.
// Ports:
//   above, centre, below : the three source rows (bit c = column c); the
//                          engine supplies zero rows for out-of-grid rows
//   birth_mask           : bit n set -> dead cell with n neighbours is born
//   survive_mask         : bit n set -> live cell with n neighbours survives
//   next_row             : next generation of the centre row
// Column wrap (WRAP=1) or dead borders (WRAP=0) are resolved here.
module gol_row_rule
  import gol_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] centre,
  input  logic [WIDTH-1:0] below,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic [WIDTH-1:0] next_row
);

  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    localparam int CL = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int CR = (c == WIDTH - 1) ? 0 : c + 1;

    logic [2:0]       lft;
    logic [2:0]       rgt;
    logic [NBR_W-1:0] n;

    if (WRAP == 0 && c == 0) begin : g_lft_dead
      assign lft = 3'b000;
    end else begin : g_lft
      assign lft = {above[CL], centre[CL], below[CL]};
    end

    if (WRAP == 0 && c == WIDTH - 1) begin : g_rgt_dead
      assign rgt = 3'b000;
    end else begin : g_rgt
      assign rgt = {above[CR], centre[CR], below[CR]};
    end

    // Eight neighbours: three left, three right, plus above and below.
    assign n = NBR_W'(lft[0]) + NBR_W'(lft[1]) + NBR_W'(lft[2])
             + NBR_W'(rgt[0]) + NBR_W'(rgt[1]) + NBR_W'(rgt[2])
             + NBR_W'(above[c]) + NBR_W'(below[c]);

    assign next_row[c] = centre[c] ? survive_mask[n] : birth_mask[n];
  end

endmodule

// File: rtl/gol_grid_engine.sv
// Game-of-Life generation engine.
// Holds a WIDTH x HEIGHT grid, accepts host row writes while idle, and on a
// step request computes one row per cycle into a shadow buffer, then commits
// the whole generation in a single cycle (HEIGHT+1 cycles per generation).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   load_valid/ready/row/data  : host row write (accepted only while idle)
//   step_valid/ready/count     : run request, 0 generations treated as 1
//   stop_on_stable             : end the run early once the grid stops changing
//   birth_mask, survive_mask   : rule masks, latched at step accept
//   busy, done                 : run in progress / one-cycle end-of-run pulse
//   stable, extinct            : last commit unchanged / grid all zero
//   gen_count                  : generations committed since reset (wraps)
//   grid_flat                  : current grid, bit r*WIDTH+c = cell (r,c)
module gol_grid_engine
  import gol_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int WRAP   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [$clog2(HEIGHT)-1:0] load_row,
  input  logic [WIDTH-1:0]          load_data,
  input  logic                      step_valid,
  output logic                      step_ready,
  input  logic [CNT_W-1:0]          step_count,
  input  logic                      stop_on_stable,
  input  logic [8:0]                birth_mask,
  input  logic [8:0]                survive_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      stable,
  output logic                      extinct,
  output logic [CNT_W-1:0]          gen_count,
  output logic [WIDTH*HEIGHT-1:0]   grid_flat
);

  localparam int ROW_W = $clog2(HEIGHT);

  state_t                        state;
  logic [HEIGHT-1:0][WIDTH-1:0]  grid;
  logic [HEIGHT-1:0][WIDTH-1:0]  shadow;
  logic [HEIGHT-1:0][WIDTH-1:0]  grid_ld;
  logic [ROW_W-1:0]              row_ptr;
  logic [ROW_W-1:0]              up_idx;
  logic [ROW_W-1:0]              dn_idx;
  logic [CNT_W-1:0]              remaining;
  logic [8:0]                    birth_q;
  logic [8:0]                    survive_q;
  logic                          sos_q;
  logic                          load_ok;
  logic                          same_now;
  logic [WIDTH-1:0]              row_up;
  logic [WIDTH-1:0]              row_mid;
  logic [WIDTH-1:0]              row_dn;
  logic [WIDTH-1:0]              row_next;

  assign load_ready = (state == IDLE);
  assign step_ready = (state == IDLE);
  assign grid_flat  = grid;
  assign same_now   = (shadow == grid);
  assign load_ok    = load_valid && (int'(load_row) < HEIGHT);

  // Grid as it will look after this cycle's host write, so extinct can be
  // recomputed in the same edge that stores the row.
  always_comb begin
    grid_ld = grid;
    if (load_ok) grid_ld[load_row] = load_data;
  end

  // Source rows for the row being computed; edge rows read as dead when
  // the grid does not wrap.
  always_comb begin
    up_idx  = (row_ptr == '0) ? ROW_W'(HEIGHT - 1) : row_ptr - 1'b1;
    dn_idx  = (row_ptr == ROW_W'(HEIGHT - 1)) ? '0 : row_ptr + 1'b1;
    row_up  = grid[up_idx];
    row_mid = grid[row_ptr];
    row_dn  = grid[dn_idx];
    if (WRAP == 0) begin
      if (row_ptr == '0) row_up = '0;
      if (row_ptr == ROW_W'(HEIGHT - 1)) row_dn = '0;
    end
  end

  gol_row_rule #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_row_rule (
    .above        (row_up),
    .centre       (row_mid),
    .below        (row_dn),
    .birth_mask   (birth_q),
    .survive_mask (survive_q),
    .next_row     (row_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grid      <= '0;
      shadow    <= '0;
      row_ptr   <= '0;
      remaining <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      sos_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stable    <= 1'b0;
      extinct   <= 1'b1;
      gen_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A same-cycle load lands now; CALC reads the grid from next cycle.
          if (load_ok) begin
            grid    <= grid_ld;
            stable  <= 1'b0;
            extinct <= (grid_ld == '0);
          end
          if (step_valid) begin
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            sos_q     <= stop_on_stable;
            remaining <= (step_count == '0) ? CNT_W'(1) : step_count;
            row_ptr   <= '0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          shadow[row_ptr] <= row_next;
          if (row_ptr == ROW_W'(HEIGHT - 1)) state <= COMMIT;
          else row_ptr <= row_ptr + 1'b1;
        end
        COMMIT: begin
          grid      <= shadow;
          gen_count <= gen_count + 1'b1;
          stable    <= same_now;
          extinct   <= (shadow == '0);
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1) || (same_now && sos_q)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            row_ptr <= '0;
            state   <= CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_grid_engine.sv
// Bench for gol_grid_engine: a wrapping 8x8 instance and a non-wrapping 8x8
// instance share all stimulus; a third instance with a 4-bit counter checks
// generation-count wrap. Expected results come from a behavioural life model
// and are queued at step time, then checked when each instance pulses done.
module tb_gol_grid_engine;
  import gol_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  typedef struct {
    logic [63:0] grid;
    logic [15:0] gen;
    logic        stable;
    logic        extinct;
    int          gens;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [2:0]  load_row;
  logic [7:0]  load_data;
  logic        step_valid;
  logic [15:0] step_count;
  logic        sos;
  logic [8:0]  bm, sm;
  logic        step_valid_c4;
  logic [3:0]  step_count_c4;

  logic        load_ready [2];
  logic        step_ready [2];
  logic        busy [2];
  logic        done [2];
  logic        stable [2];
  logic        extinct [2];
  logic [15:0] genv [2];
  logic [63:0] gf [2];

  logic        load_ready_c4, step_ready_c4, busy_c4, done_c4, stable_c4, extinct_c4;
  logic [3:0]  gen_c4;
  logic [63:0] gf_c4;

  int          total = 0;
  int          bad = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [63:0] mg [2];
  logic [15:0] exp_gen [2];
  logic [3:0]  exp_c4;

  always #5 clk = ~clk;

  gol_grid_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[0]),
    .load_row(load_row), .load_data(load_data), .step_valid(step_valid),
    .step_ready(step_ready[0]), .step_count(step_count), .stop_on_stable(sos),
    .birth_mask(bm), .survive_mask(sm), .busy(busy[0]), .done(done[0]),
    .stable(stable[0]), .extinct(extinct[0]), .gen_count(genv[0]), .grid_flat(gf[0]));

  gol_grid_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[1]),
    .load_row(load_row), .load_data(load_data), .step_valid(step_valid),
    .step_ready(step_ready[1]), .step_count(step_count), .stop_on_stable(sos),
    .birth_mask(bm), .survive_mask(sm), .busy(busy[1]), .done(done[1]),
    .stable(stable[1]), .extinct(extinct[1]), .gen_count(genv[1]), .grid_flat(gf[1]));

  gol_grid_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_c4),
    .load_row(load_row), .load_data(load_data), .step_valid(step_valid_c4),
    .step_ready(step_ready_c4), .step_count(step_count_c4), .stop_on_stable(sos),
    .birth_mask(bm), .survive_mask(sm), .busy(busy_c4), .done(done_c4),
    .stable(stable_c4), .extinct(extinct_c4), .gen_count(gen_c4), .grid_flat(gf_c4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] next_gen(input logic [63:0] g, input logic [8:0] b,
                                           input logic [8:0] s, input bit wrap);
    logic [63:0] o;
    int n, rr, cc;
    o = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
              continue;
            end
            n += int'(g[rr*W+cc]);
          end
        end
        o[r*W+c] = g[r*W+c] ? s[n] : b[n];
      end
    end
    return o;
  endfunction

  task automatic model_run(input int k, input int cnt, input bit so, output exp_t e);
    logic [63:0] g, ng;
    int rem;
    g = mg[k];
    rem = (cnt == 0) ? 1 : cnt;
    e.gens = 0;
    do begin
      ng = next_gen(g, bm, sm, k == 0);
      e.gens++;
      e.stable = (ng == g);
      e.extinct = (ng == '0);
      g = ng;
      rem--;
    end while (rem > 0 && !(e.stable && so));
    mg[k] = g;
    exp_gen[k] = exp_gen[k] + 16'(e.gens);
    e.grid = g;
    e.gen = exp_gen[k];
  endtask

  task automatic load_one(input int r, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_row = 3'(r);
    load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 2; k++) mg[k][r*W +: W] = d;
  endtask

  task automatic load_grid(input logic [63:0] g);
    for (int r = 0; r < H; r++) load_one(r, g[r*W +: W]);
  endtask

  // Drives one step request (optionally with a same-cycle row write) and
  // queues the model's expectations for both 8x8 instances.
  task automatic step_start(input int cnt, input bit so, input bit ld,
                            input int ld_r, input logic [7:0] ld_d);
    exp_t e;
    @(negedge clk);
    step_valid = 1'b1;
    step_count = 16'(cnt);
    sos = so;
    if (ld) begin
      load_valid = 1'b1;
      load_row = 3'(ld_r);
      load_data = ld_d;
      for (int k = 0; k < 2; k++) mg[k][ld_r*W +: W] = ld_d;
    end
    model_run(0, cnt, so, e);
    sb0.push_back(e);
    model_run(1, cnt, so, e);
    sb1.push_back(e);
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input bit chk_lat);
    bit seen [2];
    exp_t e;
    int c, cyc0, gens0;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    c = 0;
    cyc0 = -1;
    gens0 = 0;
    while (!(seen[0] && seen[1]) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
      for (int k = 0; k < 2; k++) begin
        if (!seen[k] && done[k]) begin
          seen[k] = 1'b1;
          if (k == 0) e = sb0.pop_front();
          else e = sb1.pop_front();
          if (k == 0) begin
            cyc0 = c;
            gens0 = e.gens;
          end
          check($sformatf("grid%0d", k), gf[k], e.grid);
          check($sformatf("gen%0d", k), 64'(genv[k]), 64'(e.gen));
          check($sformatf("stable%0d", k), 64'(stable[k]), 64'(e.stable));
          check($sformatf("extinct%0d", k), 64'(extinct[k]), 64'(e.extinct));
          check($sformatf("busy_at_done%0d", k), 64'(busy[k]), 64'(0));
        end
      end
    end
    check("done0_seen", 64'(seen[0]), 64'(1));
    check("done1_seen", 64'(seen[1]), 64'(1));
    if (chk_lat) check("latency", 64'(cyc0), 64'(gens0 * (H + 1)));
  endtask

  task automatic run_c4(input int cnt);
    int c;
    bit seen;
    @(negedge clk);
    step_valid_c4 = 1'b1;
    step_count_c4 = 4'(cnt);
    exp_c4 = exp_c4 + 4'(cnt);
    @(posedge clk);
    #1;
    step_valid_c4 = 1'b0;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 400) begin
      @(posedge clk);
      #1;
      c++;
      seen = done_c4;
    end
    check("c4_done_seen", 64'(seen), 64'(1));
    check("c4_latency", 64'(c), 64'(cnt * (H + 1)));
  endtask

  logic [63:0] glider;
  logic [63:0] blinker_v;

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_row = '0;
    load_data = '0;
    step_valid = 1'b0;
    step_count = '0;
    sos = 1'b0;
    bm = RULE_CONWAY_B;
    sm = RULE_CONWAY_S;
    step_valid_c4 = 1'b0;
    step_count_c4 = '0;
    exp_c4 = '0;
    for (int k = 0; k < 2; k++) begin
      mg[k] = '0;
      exp_gen[k] = '0;
    end
    glider = 64'h0000_0000_0007_0402;
    blinker_v = 64'h0000_0008_0808_0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 2; k++) begin
      check("rst_grid", gf[k], 64'(0));
      check("rst_busy", 64'(busy[k]), 64'(0));
      check("rst_done", 64'(done[k]), 64'(0));
      check("rst_stable", 64'(stable[k]), 64'(0));
      check("rst_extinct", 64'(extinct[k]), 64'(1));
      check("rst_gen", 64'(genv[k]), 64'(0));
      check("rst_load_ready", 64'(load_ready[k]), 64'(1));
      check("rst_step_ready", 64'(step_ready[k]), 64'(1));
    end

    // Blinker, one step
    load_one(3, 8'h1C);
    check("load_extinct", 64'(extinct[0]), 64'(0));
    step_start(1, 1'b0, 1'b0, 0, 8'h00);
    check("busy_run", 64'(busy[0]), 64'(1));
    check("step_ready_busy", 64'(step_ready[0]), 64'(0));
    wait_done(1'b1);
    check("blinker_const", gf[0], blinker_v);
    check("blinker_nw_const", gf[1], blinker_v);

    // Block with early stop
    load_grid(64'h0000_0018_1800_0000);
    check("load_clears_stable", 64'(stable[0]), 64'(0));
    step_start(5, 1'b1, 1'b0, 0, 8'h00);
    wait_done(1'b1);
    check("block_stable", 64'(stable[0]), 64'(1));

    // Glider over 32 generations, toroidal and bounded
    load_grid(glider);
    step_start(32, 1'b0, 1'b0, 0, 8'h00);
    wait_done(1'b1);
    check("glider_returns", gf[0], glider);
    check("glider_nw_block", 64'($countones(gf[1])), 64'(4));

    // Empty grid, Conway then birth-on-zero; step_count 0 runs once
    load_grid(64'h0);
    check("load_zero_extinct", 64'(extinct[0]), 64'(1));
    step_start(0, 1'b0, 1'b0, 0, 8'h00);
    wait_done(1'b1);
    bm = 9'h001;
    step_start(1, 1'b0, 1'b0, 0, 8'h00);
    bm = RULE_CONWAY_B;
    wait_done(1'b1);
    check("birth0_all_ones", gf[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // Writes and mask changes while busy are ignored
    load_grid(64'h0000_0000_1C00_0000);
    step_start(1, 1'b0, 1'b0, 0, 8'h00);
    @(negedge clk);
    load_valid = 1'b1;
    load_row = 3'd0;
    load_data = 8'hFF;
    bm = 9'h1FF;
    sm = 9'h000;
    #1;
    check("load_ready_busy", 64'(load_ready[0]), 64'(0));
    @(negedge clk);
    load_valid = 1'b0;
    bm = RULE_CONWAY_B;
    sm = RULE_CONWAY_S;
    wait_done(1'b0);

    // Same-cycle load and step
    load_grid(64'h0);
    step_start(1, 1'b0, 1'b1, 3, 8'h1C);
    wait_done(1'b1);
    check("same_cycle_blinker", gf[0], blinker_v);

    // Reset mid-run while computing row 4
    load_grid(glider);
    step_start(5, 1'b0, 1'b0, 0, 8'h00);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("abort_grid", gf[k], 64'(0));
      check("abort_gen", 64'(genv[k]), 64'(0));
      check("abort_extinct", 64'(extinct[k]), 64'(1));
      check("abort_busy", 64'(busy[k]), 64'(0));
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 64'(done[0] | done[1]), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb0.delete();
    sb1.delete();
    for (int k = 0; k < 2; k++) begin
      mg[k] = '0;
      exp_gen[k] = '0;
    end
    exp_c4 = '0;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("post_abort_no_done", 64'(done[0] | done[1]), 64'(0));
    end
    check("post_abort_ready", 64'(step_ready[0]), 64'(1));

    // 4-bit generation counter wraps after 16 commits
    run_c4(15);
    check("c4_gen15", 64'(gen_c4), 64'(exp_c4));
    run_c4(2);
    check("c4_gen_wrap", 64'(gen_c4), 64'(exp_c4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
